extclk_freq_meter: RTL
======================

# extclk_freq_meter

Multi-channel frequency meter for external clocks such as DUT_CLK and auxiliary target clocks. It generalises the single-channel, asynchronously gated edge counter in the top-level interface into a parametrised, fully synchronous block with three additions: a programmable gate window, back-to-back continuous mode, and saturation/overflow reporting. It sits beside `usb_interface` on the system clock, and its selected result feeds the `extclk_frequency` register.

## Interface
Parameters:
- `NUM_CH`, default 4: number of measured inputs, 1..16.
- `CNT_WIDTH`, default 32: width of each edge counter and result.
- `GATE_WIDTH`, default 26: width of the gate-length register.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock; every register is clocked on its rising edge.
- `reset` in 1: synchronous, active-high; overrides all other inputs.
- `sig_i` in NUM_CH: measured signals, asynchronous to `clk`.
- `gate_len_i` in GATE_WIDTH: gate window length in `clk` cycles.
- `start_i` in 1: level-sampled request to start a measurement.
- `continuous_i` in 1: 1 = restart automatically at the end of each window.
- `abort_i` in 1: stop the current measurement and discard it.
- `ch_sel_i` in clog2(NUM_CH), minimum 1: readout channel select.
- `freq_o` out CNT_WIDTH: result of the channel selected by `ch_sel_i`.
- `ovf_o` out NUM_CH: per-channel overflow flags for the last result.
- `busy_o` out 1: high while the block is in GATE.
- `valid_o` out 1: one-cycle pulse when new results are latched.

## Operation
- Input path per channel: synchroniser, then a history register `s_d`. `edge = s_sync & ~s_d`, so only rising edges count. Maximum measurable frequency is below clk/2.
- State machine has two states, IDLE and GATE.
- IDLE -> GATE when `start_i`=1 and `gate_len_i`!=0. On that cycle:
  - load the gate counter with `gate_len_i`;
  - clear all edge counters and running overflow bits.
- If `gate_len_i`==0, `start_i` is ignored and the block stays in IDLE.
- Each GATE cycle:
  - each channel counter adds its `edge`;
  - a counter at all-ones holds (saturates) and sets its running overflow bit;
  - the gate counter decrements.
- Last GATE cycle (gate counter == 1):
  - result[ch] <= counter + edge, saturating;
  - result overflow[ch] <= running overflow, or the saturation that occurs in this cycle;
  - `valid_o` pulses on the next cycle.
  - If `continuous_i`=1 and `gate_len_i`!=0: reload the gate counter, clear the counters, stay in GATE. Windows run back-to-back with no dead cycles and no lost edges.
  - Otherwise go to IDLE.
- `abort_i` in GATE: go to IDLE, results unchanged, no `valid_o`. If abort coincides with the last cycle, abort wins. `abort_i` in IDLE has no effect.
- `start_i` while in GATE is ignored.
- `gate_len_i` is sampled only at start and at each continuous reload.
- Readout: `freq_o` <= result[`ch_sel_i`], registered. A `ch_sel_i` >= NUM_CH reads 0.
- `ovf_o` is the registered result overflow vector.

## Timing
- Reset values:
  - `freq_o`=0, `ovf_o`=0, `busy_o`=0, `valid_o`=0;
  - all results, counters, synchroniser and history registers 0;
  - state IDLE.
- Reset mid-GATE discards the measurement. Results return to 0.
- `busy_o` rises the cycle after accepted `start_i`. It falls the cycle after the last GATE cycle in single-shot mode, and the cycle after an abort.
- A window covers exactly `gate_len_i` edge samples.
- `valid_o` is high for the cycle after the last GATE cycle.
- `freq_o` shows the new result in the same cycle as `valid_o`. Latency from `ch_sel_i` change to `freq_o` is 1 cycle.
- Latency from `sig_i` rising to counted edge: 3 cycles with sync enabled, 2 cycles without.

## Configuration
- `FREQMETER_SYNC_EN` defined: 2-flop synchroniser on each `sig_i` before the history register. Use this for truly asynchronous inputs; it is the default build.
- Not defined: single input register only, saving one flop per channel. Only for `sig_i` already synchronous to `clk`.
- Counts for periodic input are identical in both builds. Only the latency differs.

## Test plan
- Single-shot count: ch0 rises every 4 clk, ch1 every 10, ch2 held 0, ch3 held 1. `gate_len_i`=1000, one `start_i` pulse.
  - Expect `valid_o` once; results 250, 100, 0, 0; `ovf_o`=0; `busy_o` high for exactly 1000 cycles.
- Saturation: `CNT_WIDTH`=8, ch0 rises every 2 clk, gate 1000.
  - Expect result 255, `ovf_o[0]`=1, other channels' flags 0.
- Continuous mode: `continuous_i`=1, gate 500, ch0 rises every 5 clk.
  - Expect `valid_o` every 500 cycles, each result 100 (±0 with phase held); `busy_o` stays high.
  - Drop `continuous_i`: the block ends after the current window.
- Abort and collision: `abort_i` at cycle 300 of 1000 leaves the previous results and gives no `valid_o`. `abort_i` coincident with the last cycle also gives no `valid_o`.
- Boundaries: `gate_len_i`=0 with `start_i` keeps the block IDLE. `gate_len_i`=1 gives a one-cycle window, result 0 or 1.
- Boundaries: `start_i` during GATE is ignored. `ch_sel_i`=NUM_CH reads 0.
- Reset mid-GATE at cycle 400: all outputs 0 on the next cycle, state IDLE. A new start gives correct counts.

Source files
------------

// File: rtl/extclk_freq_meter.sv
// extclk_freq_meter
//   Multi-channel edge-counting frequency meter for external clocks. Every
//   channel counts rising edges of its input over a programmable gate window
//   of clk cycles. Windows can run single-shot or back-to-back (continuous),
//   and a counter that fills up saturates and flags overflow for that window.
//
//   Build option: define FREQMETER_SYNC_EN to put a 2-flop synchroniser on
//   each sig_i (for truly asynchronous inputs). Without it, each input gets a
//   single register only (for inputs already synchronous to clk).
//
// Ports
//   clk          system clock, all registers on its rising edge
//   reset        synchronous, active-high
//   sig_i        measured inputs, one per channel
//   gate_len_i   window length in clk cycles (0 = start refused)
//   start_i      level-sampled start request (ignored while measuring)
//   continuous_i restart automatically at the end of each window
//   abort_i      drop the running window, keep the previous results
//   ch_sel_i     readout channel select for freq_o
//   freq_o       registered result of the selected channel (0 if out of range)
//   ovf_o        registered per-channel overflow flags of the last result
//   busy_o       high while a window is running
//   valid_o      one-cycle pulse when new results are latched
//
// State table
//   state   | meaning
//   ST_IDLE | waiting for start_i with a non-zero gate length
//   ST_GATE | window running, edge counters accumulating
module extclk_freq_meter #(
  parameter int NUM_CH     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 26,
  localparam int SEL_WIDTH = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_CH-1:0]     sig_i,
  input  logic [GATE_WIDTH-1:0] gate_len_i,
  input  logic                  start_i,
  input  logic                  continuous_i,
  input  logic                  abort_i,
  input  logic [SEL_WIDTH-1:0]  ch_sel_i,
  output logic [CNT_WIDTH-1:0]  freq_o,
  output logic [NUM_CH-1:0]     ovf_o,
  output logic                  busy_o,
  output logic                  valid_o
);

  typedef enum logic {ST_IDLE = 1'b0, ST_GATE = 1'b1} state_t;

  state_t state_q, state_d;

`ifdef FREQMETER_SYNC_EN
  logic [NUM_CH-1:0] meta_q, meta_d;
`endif
  logic [NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0] hist_q, hist_d;

  logic [GATE_WIDTH-1:0] gate_cnt_q, gate_cnt_d;
  logic [CNT_WIDTH-1:0]  cnt_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     run_ovf_q, run_ovf_d;
  logic [CNT_WIDTH-1:0]  result_q [NUM_CH];
  logic [CNT_WIDTH-1:0]  result_d [NUM_CH];
  logic [NUM_CH-1:0]     res_ovf_q, res_ovf_d;
  logic [CNT_WIDTH-1:0]  freq_q, freq_d;
  logic [NUM_CH-1:0]     ovf_q, ovf_d;
  logic                  valid_q, valid_d;

  logic [NUM_CH-1:0]     rise_w;
  logic [NUM_CH-1:0]     sat_hit;
  logic [CNT_WIDTH-1:0]  cnt_inc [NUM_CH];

  logic gate_run;
  logic last_cycle;
  logic reload_ok;
  logic accept;
  logic load;

  // Input path: optional synchroniser, then history register for edge detect.
  always_comb begin
`ifdef FREQMETER_SYNC_EN
    meta_d = sig_i;
    sync_d = meta_q;
`else
    sync_d = sig_i;
`endif
    hist_d = sync_q;
    rise_w = sync_q & ~hist_q;
  end

  assign gate_run   = (state_q == ST_GATE) && !abort_i;
  assign last_cycle = (gate_cnt_q == GATE_WIDTH'(1));
  assign reload_ok  = continuous_i && (gate_len_i != '0);
  assign accept     = (state_q == ST_IDLE) && start_i && (gate_len_i != '0);
  // Load fires on an accepted start and on a continuous reload; the reload
  // cycle still folds its own edge into the result, so no edge is lost.
  assign load       = accept || (gate_run && last_cycle && reload_ok);

  // Per-channel saturating increment; sat_hit marks an edge lost to saturation.
  always_comb begin
    sat_hit = '0;
    cnt_inc = cnt_q;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (&cnt_q[ch]) begin
        sat_hit[ch] = rise_w[ch];
      end else begin
        cnt_inc[ch] = cnt_q[ch] + {{(CNT_WIDTH-1){1'b0}}, rise_w[ch]};
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over the last-cycle transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_GATE;
      end
      ST_GATE: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (last_cycle && !reload_ok) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    gate_cnt_d = gate_cnt_q;
    cnt_d      = cnt_q;
    run_ovf_d  = run_ovf_q;
    result_d   = result_q;
    res_ovf_d  = res_ovf_q;
    valid_d    = 1'b0;

    if (gate_run) begin
      gate_cnt_d = gate_cnt_q - GATE_WIDTH'(1);
      cnt_d      = cnt_inc;
      run_ovf_d  = run_ovf_q | sat_hit;
      if (last_cycle) begin
        result_d  = cnt_inc;
        res_ovf_d = run_ovf_q | sat_hit;
        valid_d   = 1'b1;
      end
    end

    if (load) begin
      gate_cnt_d = gate_len_i;
      cnt_d      = '{default: '0};
      run_ovf_d  = '0;
    end

    // Readout uses the next result so freq_o updates together with valid_o.
    freq_d = '0;
    if (32'(ch_sel_i) < NUM_CH) begin
      freq_d = result_d[ch_sel_i];
    end
    ovf_d = res_ovf_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef FREQMETER_SYNC_EN
      meta_q <= '0;
`endif
      sync_q     <= '0;
      hist_q     <= '0;
      gate_cnt_q <= '0;
      cnt_q      <= '{default: '0};
      run_ovf_q  <= '0;
      result_q   <= '{default: '0};
      res_ovf_q  <= '0;
      freq_q     <= '0;
      ovf_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
`ifdef FREQMETER_SYNC_EN
      meta_q <= meta_d;
`endif
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      gate_cnt_q <= gate_cnt_d;
      cnt_q      <= cnt_d;
      run_ovf_q  <= run_ovf_d;
      result_q   <= result_d;
      res_ovf_q  <= res_ovf_d;
      freq_q     <= freq_d;
      ovf_q      <= ovf_d;
      valid_q    <= valid_d;
    end
  end

  // Outputs
  always_comb begin
    busy_o  = (state_q == ST_GATE);
    valid_o = valid_q;
    freq_o  = freq_q;
    ovf_o   = ovf_q;
  end

endmodule
